// File: rtl/readout_sequencer.sv
// Queues host READOUT commands, holds each until the enabled tile FIFOs can
// cover its length, issues it to the result arbiter and returns a tagged status.
//
// state  | meaning
// IDLE   | waiting for a queued command; pops the head into the working regs
// CHECK  | validating the command and waiting for enough tile data
// ISSUE  | one-cycle readout_en pulse to the arbiter
// WAIT   | waiting for the arbiter done strobe (cannot be cancelled)
// RESP   | response held valid until the host accepts it
module readout_sequencer #(
    parameter int NUM_TILES      = 2,
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                           i_clk,
    input  logic                           i_reset_n,
    input  logic                           i_cmd_valid,
    output logic                           o_cmd_ready,
    input  logic [7:0]                     i_cmd_start_col,
    input  logic [31:0]                    i_cmd_rd_len,
    input  logic [7:0]                     i_cmd_tag,
    input  logic                           i_abort,
    input  logic [23:0]                    i_mc_tile_en,
    input  logic [9*NUM_TILES-1:0]         i_tile_fifo_count,
    output logic                           o_readout_en,
    output logic [7:0]                     o_readout_start_col,
    output logic [31:0]                    o_readout_rd_len,
    input  logic                           i_readout_done,
    output logic                           o_rsp_valid,
    input  logic                           i_rsp_ready,
    output logic [7:0]                     o_rsp_tag,
    output logic [1:0]                     o_rsp_status,
    output logic                           o_busy,
    output logic [$clog2(CMD_DEPTH):0]     o_queue_count
);

    localparam int PTR_W = $clog2(CMD_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [1:0] RSP_OK      = 2'd0;
    localparam logic [1:0] RSP_REJECT  = 2'd1;
    localparam logic [1:0] RSP_TIMEOUT = 2'd2;
    localparam logic [1:0] RSP_ABORT   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [7:0]         col_q, col_d;
    logic [31:0]        len_q, len_d;
    logic [7:0]         tag_q, tag_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [7:0]         ro_col_q, ro_col_d;
    logic [31:0]        ro_len_q, ro_len_d;
    logic [7:0]         rsp_tag_q, rsp_tag_d;
    logic [1:0]         rsp_status_q, rsp_status_d;

    logic [7:0]         mem_col_q [CMD_DEPTH];
    logic [31:0]        mem_len_q [CMD_DEPTH];
    logic [7:0]         mem_tag_q [CMD_DEPTH];

    logic               push;
    logic               pop;
    logic [12:0]        avail;
    logic               full_tile;
    logic               col_en;
    logic               reject;
    logic               launch;

    assign o_cmd_ready = i_reset_n && (count_q < CNT_W'(CMD_DEPTH)) && !i_abort;
    assign push        = i_cmd_valid && o_cmd_ready;
    assign pop         = (state_q == ST_IDLE) && (count_q != '0) && !i_abort;

    // Only tiles below NUM_TILES contribute; higher enable bits are don't-care.
    always_comb begin
        avail     = '0;
        full_tile = 1'b0;
        col_en    = 1'b0;
        for (int i = 0; i < NUM_TILES; i++) begin
            if (i_mc_tile_en[i]) begin
                avail = avail + 13'(i_tile_fifo_count[i*9 +: 9]);
                if (i_tile_fifo_count[i*9 +: 9] == 9'd256) begin
                    full_tile = 1'b1;
                end
            end
        end
        for (int i = 0; i < 24; i++) begin
            if ((i < NUM_TILES) && (col_q == 8'(i))) begin
                col_en = i_mc_tile_en[i];
            end
        end
    end

    assign reject = (len_q == '0) || (col_q >= 8'(NUM_TILES)) || !col_en;
    assign launch = ({19'b0, avail} >= len_q) || full_tile;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        col_d        = col_q;
        len_d        = len_q;
        tag_d        = tag_q;
        timer_d      = timer_q;
        ro_col_d     = ro_col_q;
        ro_len_d     = ro_len_q;
        rsp_tag_d    = rsp_tag_q;
        rsp_status_d = rsp_status_q;

        if (i_abort) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    col_d   = mem_col_q[rd_ptr_q];
                    len_d   = mem_len_q[rd_ptr_q];
                    tag_d   = mem_tag_q[rd_ptr_q];
                    timer_d = TMR_W'(TIMEOUT_CYCLES - 1);
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (i_abort) begin
                    rsp_tag_d    = tag_q;
                    rsp_status_d = RSP_ABORT;
                    state_d      = ST_RESP;
                end else if (reject) begin
                    rsp_tag_d    = tag_q;
                    rsp_status_d = RSP_REJECT;
                    state_d      = ST_RESP;
                end else if (launch) begin
                    ro_col_d = col_q;
                    ro_len_d = len_q;
                    state_d  = ST_ISSUE;
                end else if (timer_q == '0) begin
                    rsp_tag_d    = tag_q;
                    rsp_status_d = RSP_TIMEOUT;
                    state_d      = ST_RESP;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_readout_done) begin
                    rsp_tag_d    = tag_q;
                    rsp_status_d = RSP_OK;
                    state_d      = ST_RESP;
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            col_q        <= '0;
            len_q        <= '0;
            tag_q        <= '0;
            timer_q      <= '0;
            ro_col_q     <= '0;
            ro_len_q     <= '0;
            rsp_tag_q    <= '0;
            rsp_status_q <= '0;
            for (int i = 0; i < CMD_DEPTH; i++) begin
                mem_col_q[i] <= '0;
                mem_len_q[i] <= '0;
                mem_tag_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            col_q        <= col_d;
            len_q        <= len_d;
            tag_q        <= tag_d;
            timer_q      <= timer_d;
            ro_col_q     <= ro_col_d;
            ro_len_q     <= ro_len_d;
            rsp_tag_q    <= rsp_tag_d;
            rsp_status_q <= rsp_status_d;
            if (push) begin
                mem_col_q[wr_ptr_q] <= i_cmd_start_col;
                mem_len_q[wr_ptr_q] <= i_cmd_rd_len;
                mem_tag_q[wr_ptr_q] <= i_cmd_tag;
            end
        end
    end

    assign o_readout_en        = (state_q == ST_ISSUE);
    assign o_readout_start_col = ro_col_q;
    assign o_readout_rd_len    = ro_len_q;
    assign o_rsp_valid         = (state_q == ST_RESP);
    assign o_rsp_tag           = rsp_tag_q;
    assign o_rsp_status        = rsp_status_q;
    assign o_busy              = (state_q != ST_IDLE);
    assign o_queue_count       = count_q;

endmodule
